legv8_inst_encoder: RTL and testbench

Streaming LEGv8 instruction encoder and program emitter: accepts symbolic instructions (operation, register fields, immediate) over a valid/ready handshake, range-checks the fields, packs them into 32-bit machine words using the same opcode map the CPU control decoder recognises, and streams each word out with a sequential instruction-memory address. It sits between the testbench/boot program source and instruction memory, so programs for the CPU are generated in hardware rather than hand-assembled.

---
 rtl/legv8_pkg.sv | 56 +++++
 rtl/legv8_field_pack.sv | 68 ++++++
 rtl/legv8_inst_encoder.sv | 121 ++++++++++++
 tb/tb_legv8_inst_encoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// LEGv8 encoding constants shared by the instruction encoder and the CPU
// control decoder: symbolic op codes, the opcode fields for each format,
// the fixed NOP/HALT words, immediate ranges and error codes.
package legv8_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDUR = 4'd1,
    OP_STUR = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_AND  = 4'd5,
    OP_ORR  = 4'd6,
    OP_ADDI = 4'd7,
    OP_CBZ  = 4'd8,
    OP_CBNZ = 4'd9,
    OP_B    = 4'd10,
    OP_HALT = 4'd11
  } op_e;

  // R-type and D-type opcodes (11 bits)
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  // I-type, CB-type and B-type opcodes
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
  localparam logic [5:0]  OPC_B    = 6'b000101;

  localparam logic [31:0] NOP_WORD  = 32'hD503_201F;
  localparam logic [31:0] HALT_WORD = 32'hFFE0_0000;

  // Inclusive signed immediate ranges for each format
  localparam int ADDI_IMM_MIN = 0;
  localparam int ADDI_IMM_MAX = 4095;
  localparam int D_IMM_MIN    = -256;
  localparam int D_IMM_MAX    = 255;
  localparam int CB_IMM_MIN   = -(1 << 18);
  localparam int CB_IMM_MAX   = (1 << 18) - 1;
  localparam int B_IMM_MIN    = -(1 << 25);
  localparam int B_IMM_MAX    = (1 << 25) - 1;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;

  function automatic logic in_range(input logic signed [31:0] v,
                                    input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/legv8_field_pack.sv
// Combinational LEGv8 field packer.
// Ports:
//   op        symbolic operation (op_e encoding, 12..15 illegal)
//   rd/rn/rm  register numbers (rd doubles as Rt for D/CB formats)
//   shamt     shift amount, used by R-type only
//   imm       two's-complement immediate/offset
//   word      packed 32-bit machine word (don't-care when flagged)
//   illegal   op is not a defined operation
//   range_err immediate does not fit the op's field
module legv8_field_pack
  import legv8_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [5:0]  shamt,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_err
);

  logic signed [31:0] simm;
  assign simm = imm;

  // NOTE: every output gets a default before the case so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    word      = '0;
    illegal   = 1'b0;
    range_err = 1'b0;
    case (op)
      OP_NOP:  word = NOP_WORD;
      OP_HALT: word = HALT_WORD;
      OP_ADD:  word = {OPC_ADD, rm, shamt, rn, rd};
      OP_SUB:  word = {OPC_SUB, rm, shamt, rn, rd};
      OP_AND:  word = {OPC_AND, rm, shamt, rn, rd};
      OP_ORR:  word = {OPC_ORR, rm, shamt, rn, rd};
      OP_LDUR: begin
        word      = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
        range_err = !in_range(simm, D_IMM_MIN, D_IMM_MAX);
      end
      OP_STUR: begin
        word      = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
        range_err = !in_range(simm, D_IMM_MIN, D_IMM_MAX);
      end
      OP_ADDI: begin
        word      = {OPC_ADDI, imm[11:0], rn, rd};
        range_err = !in_range(simm, ADDI_IMM_MIN, ADDI_IMM_MAX);
      end
      OP_CBZ: begin
        word      = {OPC_CBZ, imm[18:0], rd};
        range_err = !in_range(simm, CB_IMM_MIN, CB_IMM_MAX);
      end
      OP_CBNZ: begin
        word      = {OPC_CBNZ, imm[18:0], rd};
        range_err = !in_range(simm, CB_IMM_MIN, CB_IMM_MAX);
      end
      OP_B: begin
        word      = {OPC_B, imm[25:0]};
        range_err = !in_range(simm, B_IMM_MIN, B_IMM_MAX);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/legv8_inst_encoder.sv
// Streaming LEGv8 instruction encoder / program emitter.
// Accepts symbolic instructions on a valid/ready input, packs them into
// machine words and streams them out with sequential word addresses.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      begin a program (from IDLE or DONE)
//   in_valid/in_ready          request handshake
//   in_op, in_rd, in_rn, in_rm, in_shamt, in_imm   request fields
//   out_valid/out_ready        output handshake
//   out_inst, out_addr         encoded word and its word address
//   busy, done                 RUN/DRAIN, DONE status
//   err, err_code              sticky first-error flag and cause
module legv8_inst_encoder
  import legv8_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [5:0]        in_shamt,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_cnt;   // address the next emitted word will get
  logic [31:0]       word;
  logic              illegal;
  logic              range_err;

  logic in_fire, out_fire, load, bad;

  legv8_field_pack u_pack (
    .op        (in_op),
    .rd        (in_rd),
    .rn        (in_rn),
    .rm        (in_rm),
    .shamt     (in_shamt),
    .imm       (in_imm),
    .word      (word),
    .illegal   (illegal),
    .range_err (range_err)
  );

  // The output register may be refilled in the same cycle it is drained,
  // which keeps one word per cycle flowing.
  assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign load     = in_fire && !illegal && !range_err;
  assign bad      = in_fire && (illegal || range_err);

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr_cnt  <= BASE;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_addr  <= BASE;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_RUN;
            addr_cnt <= BASE;
            err      <= 1'b0;
            err_code <= ERR_NONE;
          end
        end
        S_RUN:   if (load && (in_op == OP_HALT)) state <= S_DRAIN;
        S_DRAIN: if (out_fire) state <= S_DONE;
        default: state <= S_IDLE;
      endcase

      if (load) begin
        out_valid <= 1'b1;
        out_inst  <= word;
        out_addr  <= addr_cnt;
        addr_cnt  <= addr_cnt + 1'b1;   // wraps modulo 2^ADDR_W
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end

      // Only the first error since start is recorded.
      if (bad && !err) begin
        err      <= 1'b1;
        err_code <= illegal ? ERR_ILLEGAL : ERR_RANGE;
      end
    end
  end

endmodule

// File: tb/tb_legv8_inst_encoder.sv
// Directed self-checking bench for legv8_inst_encoder (ADDR_W=2 so the
// address wrap is reachable with a short program).
module tb_legv8_inst_encoder;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rd, in_rn, in_rm;
  logic [5:0]        in_shamt;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              busy, done, err;
  logic [1:0]        err_code;

  int checks = 0;
  int errors = 0;

  legv8_inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rn     (in_rn),
    .in_rm     (in_rm),
    .in_shamt  (in_shamt),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted; returns 1 time unit
  // after the accepting edge with in_valid dropped.
  task automatic issue(input logic [3:0] op, input logic [4:0] rd,
                       input logic [4:0] rn, input logic [4:0] rm,
                       input logic [5:0] sh, input logic [31:0] imm);
    int n;
    in_op = op; in_rd = rd; in_rn = rn; in_rm = rm;
    in_shamt = sh; in_imm = imm; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] inst,
                            input logic [31:0] addr);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_inst"}, out_inst, inst);
    check({tag, "_addr"}, 32'(out_addr), addr);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rd = '0; in_rn = '0; in_rm = '0; in_shamt = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd0);

    start = 1'b1; tick(); start = 1'b0;
    check("run_busy", 32'(busy), 32'd1);
    check("run_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back ADDI then LDUR with the sink always ready
    out_ready = 1'b1;
    issue(4'd7, 5'd1, 5'd0, 5'd0, 6'd0, 32'd5);
    expect_out("addi", 32'h9100_1401, 0);
    issue(4'd1, 5'd2, 5'd1, 5'd0, 6'd0, 32'd8);
    expect_out("ldur", 32'hF840_8022, 1);
    tick();
    check("drained_valid", 32'(out_valid), 32'd0);

    issue(4'd3, 5'd3, 5'd1, 5'd2, 6'd0, 32'd0);
    expect_out("add", 32'h8B02_0023, 2);
    tick();

    // CBZ with the sink stalled for three cycles
    out_ready = 1'b0;
    issue(4'd8, 5'd3, 5'd0, 5'd0, 6'd0, -32'sd2);
    expect_out("cbz", 32'hB4FF_FFC3, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("cbz_hold", 32'hB4FF_FFC3, 3);
      check("cbz_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("cbz_taken_valid", 32'(out_valid), 32'd0);

    // B offset one past the top of its range: consumed, nothing emitted
    issue(4'd10, 5'd0, 5'd0, 5'd0, 6'd0, 32'h0200_0000);
    check("b_range_valid", 32'(out_valid), 32'd0);
    check("b_range_err", 32'(err), 32'd1);
    check("b_range_code", 32'(err_code), 32'd2);

    // Counter was not advanced by the error; 4 words emitted so it wrapped to 0
    issue(4'd3, 5'd3, 5'd1, 5'd2, 6'd0, 32'd0);
    expect_out("add_after_err", 32'h8B02_0023, 0);
    // Illegal op accepted in the same edge the ADD drains
    issue(4'd13, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0);
    check("illegal_valid", 32'(out_valid), 32'd0);
    check("illegal_keeps_code", 32'(err_code), 32'd2);

    issue(4'd11, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0);
    expect_out("halt", 32'hFFE0_0000, 1);
    check("drain_in_ready", 32'(in_ready), 32'd0);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_done", 32'(done), 32'd0);
    tick();
    check("done_done", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_in_ready", 32'(in_ready), 32'd0);
    check("done_valid", 32'(out_valid), 32'd0);

    start = 1'b1; tick(); start = 1'b0;
    check("restart_err", 32'(err), 32'd0);
    check("restart_code", 32'(err_code), 32'd0);
    check("restart_done", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);

    // Five NOPs wrap the 2-bit address: 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      issue(4'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0);
      expect_out("nop", 32'hD503_201F, i % 4);
    end
    tick();

    // Reset with a word pending
    out_ready = 1'b0;
    issue(4'd3, 5'd3, 5'd1, 5'd2, 6'd0, 32'd0);
    expect_out("pending", 32'h8B02_0023, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_addr", 32'(out_addr), 32'd0);
    check("midrst_inst", out_inst, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_idle_ready", 32'(in_ready), 32'd0);
    check("post_rst_done", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
